// File: rtl/bus_scheduler_pkg.sv
// Shared constants and state encoding for the round-robin bus scheduler.
// Imported by the interface, the picker and the top level.
package bus_scheduler_pkg;

   localparam int NUM_SRC_DEF = 12;
   localparam int TIMEOUT_DEF = 16;
   localparam int SEL_W       = 4;
   localparam int CNT_W       = 8;

   localparam logic [SEL_W-1:0] SEL_IDLE = 4'hF;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      XFER = 1'b1
   } state_e;

endpackage : bus_scheduler_pkg

// File: rtl/bus_scheduler_if.sv
// Handshake bundle between the bus sources/destination and the scheduler.
// master is the scheduler side, slave is the requester/destination side.
interface bus_scheduler_if
   import bus_scheduler_pkg::*;
#(
   parameter int NUM_SRC = NUM_SRC_DEF
);

   logic               enable;
   logic [NUM_SRC-1:0] req;
   logic               done;
   logic [SEL_W-1:0]   bus_sel;
   logic [NUM_SRC-1:0] grant;
   logic               bus_valid;
   logic               timeout;

   modport master (
      input  enable,
      input  req,
      input  done,
      output bus_sel,
      output grant,
      output bus_valid,
      output timeout
   );

   modport slave (
      output enable,
      output req,
      output done,
      input  bus_sel,
      input  grant,
      input  bus_valid,
      input  timeout
   );

endinterface : bus_scheduler_if

// File: rtl/bus_scheduler_rr_picker.sv
// Combinational round-robin search: first set request strictly after
// last_grant, wrapping from NUM_SRC-1 back to 0.
module rr_picker
   import bus_scheduler_pkg::*;
#(
   parameter int NUM_SRC = NUM_SRC_DEF
) (
   input  logic [NUM_SRC-1:0] req,
   input  logic [SEL_W-1:0]   last_grant,
   output logic [SEL_W-1:0]   winner,
   output logic               any_req
);

   logic found;
   int   idx;

   // Offsets run 1..NUM_SRC so last_grant itself is checked last.
   always_comb begin
      winner = SEL_IDLE;
      found  = 1'b0;
      idx    = 0;
      for (int i = 1; i <= NUM_SRC; i++) begin
         idx = (int'(last_grant) + i) % NUM_SRC;
         if (!found && req[idx]) begin
            found  = 1'b1;
            winner = SEL_W'(idx);
         end
      end
   end

   assign any_req = |req;

endmodule : rr_picker

// File: rtl/bus_scheduler.sv
// Two-state bus scheduler: registers a round-robin winner, holds it until
// done or until the transfer has run TIMEOUT cycles, then idles.
module bus_scheduler
   import bus_scheduler_pkg::*;
#(
   parameter int NUM_SRC = NUM_SRC_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              rst,
   bus_scheduler_if.master   bus
);

   state_e             state_q, state_d;
   logic [SEL_W-1:0]   bus_sel_q, bus_sel_d;
   logic [SEL_W-1:0]   last_grant_q, last_grant_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               timeout_q, timeout_d;

   logic [SEL_W-1:0]   winner;
   logic               any_req;
   logic [NUM_SRC-1:0] grant_dec;

   localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(TIMEOUT - 1);
   localparam logic [SEL_W-1:0] LAST_RESET  = SEL_W'(NUM_SRC - 1);

   rr_picker #(
      .NUM_SRC    (NUM_SRC)
   ) u_picker (
      .req        (bus.req),
      .last_grant (last_grant_q),
      .winner     (winner),
      .any_req    (any_req)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         bus_sel_q    <= SEL_IDLE;
         last_grant_q <= LAST_RESET;
         cnt_q        <= '0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         bus_sel_q    <= bus_sel_d;
         last_grant_q <= last_grant_d;
         cnt_q        <= cnt_d;
         timeout_q    <= timeout_d;
      end
   end

   // done is checked before the timeout so a coinciding done ends cleanly.
   always_comb begin
      state_d      = state_q;
      bus_sel_d    = bus_sel_q;
      last_grant_d = last_grant_q;
      cnt_d        = cnt_q;
      timeout_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (bus.enable && any_req) begin
               state_d      = XFER;
               bus_sel_d    = winner;
               last_grant_d = winner;
            end
         end
         XFER: begin
            if (bus.done) begin
               state_d   = IDLE;
               bus_sel_d = SEL_IDLE;
               cnt_d     = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d   = IDLE;
               bus_sel_d = SEL_IDLE;
               cnt_d     = '0;
               timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d   = IDLE;
            bus_sel_d = SEL_IDLE;
            cnt_d     = '0;
         end
      endcase
   end

   // Grant is a pure decode of the registered select; the idle code hits no bit.
   always_comb begin
      grant_dec = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         grant_dec[i] = (bus_sel_q == SEL_W'(i));
      end
   end

   assign bus.bus_sel   = bus_sel_q;
   assign bus.grant     = grant_dec;
   assign bus.bus_valid = (state_q == XFER);
   assign bus.timeout   = timeout_q;

endmodule : bus_scheduler
